// File: rtl/equiv_monitor.sv
// equiv_monitor
//   Compares the outputs of a pre-synthesis design (y_gold) and its
//   synthesized counterpart (y_test) over one run of valid samples. A run
//   begins with a start pulse. The first WARMUP valid samples are skipped.
//   The next NUM_SAMPLES valid samples are compared. The monitor then parks
//   in DONE and holds its results until the next start.
//
//   Optional feature: define EQUIV_MONITOR_MISR_EN to add a 32-bit MISR
//   signature over every compared y_gold sample.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   one-cycle pulse that begins a run (ignored while busy)
//   in_valid       in   y_gold/y_test hold a comparable sample this cycle
//   y_gold         in   [WIDTH-1:0] reference output
//   y_test         in   [WIDTH-1:0] output under test
//   busy           out  run in progress (WARMUP or RUN)
//   done           out  run finished, results valid
//   pass           out  done and no mismatches
//   mismatch_cnt   out  [CNT_W-1:0] saturating count of mismatching samples
//   first_fail_idx out  [CNT_W-1:0] compared-sample index of first mismatch
//   first_fail_bit out  [$clog2(WIDTH)-1:0] lowest differing bit of first mismatch
//   signature      out  [31:0] MISR signature (EQUIV_MONITOR_MISR_EN only)
module equiv_monitor #(
  parameter int WIDTH       = 284,
  parameter int WARMUP      = 4,
  parameter int NUM_SAMPLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic [WIDTH-1:0]                    y_gold,
  input  logic [WIDTH-1:0]                    y_test,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [CNT_W-1:0]                    mismatch_cnt,
  output logic [CNT_W-1:0]                    first_fail_idx,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] first_fail_bit
`ifdef EQUIV_MONITOR_MISR_EN
  ,
  output logic [31:0]                         signature
`endif
);

  localparam int FB_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Sample and warm-up counters are sized from their own limits, not CNT_W,
  // so a narrow CNT_W only limits the reported values, never the run length.
  localparam int SMP_W = $clog2(NUM_SAMPLES + 1);
  localparam int WRM_W = $clog2(WARMUP + 2);

  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(NUM_SAMPLES - 1);
  localparam logic [WRM_W-1:0] WRM_LAST = WRM_W'((WARMUP > 0) ? WARMUP - 1 : 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] ST_FIRST  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

  logic [1:0]       state;
  logic [WRM_W-1:0] warm_cnt;
  logic [SMP_W-1:0] smp_idx;

  logic [WIDTH-1:0] diff_p0;
  logic             mism_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Scanning from the top down leaves the lowest set index in r.
  function automatic logic [FB_W-1:0] low_bit(input logic [WIDTH-1:0] d);
    logic [FB_W-1:0] r;
    r = '1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i]) r = FB_W'(i);
    end
    return r;
  endfunction

`ifdef EQUIV_MONITOR_MISR_EN
  localparam int          NSL       = (WIDTH + 31) / 32;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  function automatic logic [31:0] fold(input logic [WIDTH-1:0] v);
    logic [NSL*32-1:0] p;
    logic [31:0]       f;
    p = '0;
    p[WIDTH-1:0] = v;
    f = '0;
    for (int s = 0; s < NSL; s++) f = f ^ p[s*32 +: 32];
    return f;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0) ^ d;
  endfunction
`endif

  // Stage p0: combinational compare of the current sample
  assign diff_p0 = y_gold ^ y_test;
  assign mism_p0 = |diff_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      warm_cnt       <= '0;
      smp_idx        <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
      first_fail_bit <= '1;
`ifdef EQUIV_MONITOR_MISR_EN
      signature      <= MISR_SEED;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state          <= ST_FIRST;
            warm_cnt       <= '0;
            smp_idx        <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '1;
            first_fail_bit <= '1;
`ifdef EQUIV_MONITOR_MISR_EN
            signature      <= MISR_SEED;
`endif
          end
        end
        ST_WARMUP: begin
          if (in_valid) begin
            if (warm_cnt == WRM_LAST) state <= ST_RUN;
            else                      warm_cnt <= warm_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            if (mism_p0) begin
              mismatch_cnt <= sat_inc(mismatch_cnt);
              // Saturation never returns the count to zero, so zero marks
              // the first mismatch of the run.
              if (mismatch_cnt == '0) begin
                first_fail_idx <= CNT_W'(smp_idx);
                first_fail_bit <= low_bit(diff_p0);
              end
            end
`ifdef EQUIV_MONITOR_MISR_EN
            signature <= misr_step(signature, fold(y_gold));
`endif
            if (smp_idx == SMP_LAST) state <= ST_DONE;
            else                     smp_idx <= smp_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: status decoded from the registered state
  assign busy = (state == ST_WARMUP) || (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign pass = done && (mismatch_cnt == '0);

endmodule
